// File: rtl/vx_gpu_pkg.sv
// vx_gpu_pkg: shared defaults and the CSR sequencer state encoding.
// Contents: NUM_LSU_LANES, VX_CSR_ADDR_BITS, lsu_csr_state_e {IDLE, ISSUE, RSP}.
package vx_gpu_pkg;
  localparam int NUM_LSU_LANES = 4;
  localparam int VX_CSR_ADDR_BITS = 12;
  typedef enum logic [1:0] {IDLE, ISSUE, RSP} lsu_csr_state_e;
endpackage

// File: rtl/vx_rr_arbiter.sv
// vx_rr_arbiter: round-robin arbiter whose pointer moves past the winner on advance.
// Ports: clk, reset (async active-low), requests[NUM_REQS], advance,
//        grant[NUM_REQS] (one-hot), index[IDX_BITS].
module vx_rr_arbiter #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                advance,
  output logic [NUM_REQS-1:0] grant,
  output logic [(NUM_REQS > 1 ? $clog2(NUM_REQS) : 1)-1:0] index
);
  localparam int IDX_BITS = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
  logic [IDX_BITS-1:0] ptr;
  logic [IDX_BITS:0] sum;
  // Scan from the farthest candidate down to ptr so the nearest one wins.
  always_comb begin
    grant = '0;
    index = '0;
    sum = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_BITS+1)'(i);
      if (sum >= (IDX_BITS+1)'(NUM_REQS)) sum = sum - (IDX_BITS+1)'(NUM_REQS);
      if (requests[sum[IDX_BITS-1:0]]) begin
        index = sum[IDX_BITS-1:0];
        grant = '0;
        grant[sum[IDX_BITS-1:0]] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (advance) ptr <= (index == IDX_BITS'(NUM_REQS - 1)) ? '0 : index + 1'b1;
endmodule

// File: rtl/vx_lsu_csr_sequencer.sv
// vx_lsu_csr_sequencer: serialises multi-requester CSR accesses into single-cycle strobes.
// Ports: clk, reset (async active-low); req_valid/req_rw/req_addr/req_data -> req_ready;
//        rsp_valid/rsp_idx/rsp_data <- rsp_ready; csr_write_* / csr_read_* strobes with
//        same-cycle csr_read_data. Macro LSU_CSR_PERF_EN adds perf_reads/perf_writes/perf_stalls.
import vx_gpu_pkg::*;
module vx_lsu_csr_sequencer #(
  parameter int NUM_REQS = 2,
  parameter int NUM_LANES = NUM_LSU_LANES,
  parameter int ADDR_BITS = VX_CSR_ADDR_BITS
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  req_valid,
  input  logic [NUM_REQS-1:0]                  req_rw,
  input  logic [NUM_REQS-1:0][ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][31:0] req_data,
  output logic [NUM_REQS-1:0]                  req_ready,
  output logic                                 rsp_valid,
  output logic [(NUM_REQS > 1 ? $clog2(NUM_REQS) : 1)-1:0] rsp_idx,
  output logic [NUM_LANES-1:0][31:0]           rsp_data,
  input  logic                                 rsp_ready,
  output logic                                 csr_write_enable,
  output logic [ADDR_BITS-1:0]                 csr_write_addr,
  output logic [NUM_LANES-1:0][31:0]           csr_write_data,
  output logic                                 csr_read_enable,
  output logic [ADDR_BITS-1:0]                 csr_read_addr,
  input  logic [NUM_LANES-1:0][31:0]           csr_read_data
`ifdef LSU_CSR_PERF_EN
  ,
  output logic [31:0]                          perf_reads,
  output logic [31:0]                          perf_writes,
  output logic [31:0]                          perf_stalls
`endif
);
  localparam int IDX_BITS = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;
  lsu_csr_state_e state, state_n;
  logic [NUM_REQS-1:0] grant;
  logic [IDX_BITS-1:0] win_idx, idx_q;
  logic fire, rw_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [NUM_LANES-1:0][31:0] data_q;
  assign fire = |(req_valid & req_ready);
  vx_rr_arbiter #(.NUM_REQS(NUM_REQS)) u_arb (
    .clk(clk),
    .reset(reset),
    .requests(req_valid),
    .advance(fire),
    .grant(grant),
    .index(win_idx)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // req_ready is also gated by reset so every output is 0 while reset is held.
  always_comb begin
    state_n = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    csr_write_enable = 1'b0;
    csr_read_enable = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset ? grant : '0;
        state_n = fire ? ISSUE : IDLE;
      end
      ISSUE: begin
        csr_write_enable = rw_q;
        csr_read_enable = !rw_q;
        state_n = rw_q ? IDLE : RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        state_n = rsp_ready ? IDLE : RSP;
      end
      default: state_n = IDLE;
    endcase
  end
  assign csr_write_addr = csr_write_enable ? addr_q : '0;
  assign csr_write_data = csr_write_enable ? data_q : '0;
  assign csr_read_addr = csr_read_enable ? addr_q : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rw_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      idx_q <= '0;
      rsp_idx <= '0;
      rsp_data <= '0;
    end else begin
      if (fire) begin
        rw_q <= req_rw[win_idx];
        addr_q <= req_addr[win_idx];
        data_q <= req_data[win_idx];
        idx_q <= win_idx;
      end
      if (csr_read_enable) begin
        rsp_data <= csr_read_data;
        rsp_idx <= idx_q;
      end
    end
`ifdef LSU_CSR_PERF_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      perf_reads <= '0;
      perf_writes <= '0;
      perf_stalls <= '0;
    end else begin
      perf_reads <= perf_reads + 32'(csr_read_enable);
      perf_writes <= perf_writes + 32'(csr_write_enable);
      perf_stalls <= perf_stalls + 32'(|req_valid && !fire);
    end
`endif
endmodule

// File: doc/vx_lsu_csr_sequencer.md
VX_LSU_CSR_SEQUENCER -- requirements
Module: VX_lsu_csr_sequencer

Interface
REQ-001 SHALL have parameters: NUM_REQS, default 2, number of requesters; NUM_LANES, default `NUM_LSU_LANES, data lanes; ADDR_BITS, default `VX_CSR_ADDR_BITS, CSR address width.
REQ-002 SHALL define IDX_BITS = max(1, clog2(NUM_REQS)).
REQ-003 SHALL have ports, in this order:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQS  request valid, one bit per requester.
- req_rw  in  NUM_REQS  1 = write, 0 = read.
- req_addr  in  NUM_REQS x ADDR_BITS  CSR address.
- req_data  in  NUM_REQS x NUM_LANES x 32  write data.
- req_ready  out  NUM_REQS  request accepted.
- rsp_valid  out  1  read response valid.
- rsp_idx  out  IDX_BITS  requester index of the response.
- rsp_data  out  NUM_LANES x 32  read data.
- rsp_ready  in  1  response consumer ready.
- csr_write_enable  out  1  CSR write strobe.
- csr_write_addr  out  ADDR_BITS  CSR write address.
- csr_write_data  out  NUM_LANES x 32  CSR write data.
- csr_read_enable  out  1  CSR read strobe.
- csr_read_addr  out  ADDR_BITS  CSR read address.
- csr_read_data  in  NUM_LANES x 32  CSR read data; valid in the same cycle as csr_read_enable.

Function
REQ-004 SHALL implement a 3-state FSM: IDLE, ISSUE, RSP.
REQ-005 IDLE: round-robin arbiter selects one asserted req_valid; only req_ready[winner] SHALL be 1, and only in IDLE.
REQ-006 On a req_valid & req_ready handshake, the FSM SHALL latch rw, addr, data and index, and go to ISSUE next cycle.
REQ-007 The round-robin pointer SHALL move to winner+1 (mod NUM_REQS) on each handshake and SHALL NOT change otherwise.
REQ-008 ISSUE: exactly one of csr_write_enable or csr_read_enable SHALL be 1, for exactly one cycle, driven from the latched registers.
REQ-009 ISSUE with a write: the FSM SHALL go to IDLE; writes SHALL NOT produce a response.
REQ-010 ISSUE with a read: the block SHALL capture csr_read_data into rsp_data and the latched index into rsp_idx, then go to RSP.
REQ-011 RSP: rsp_valid SHALL be 1; rsp_data and rsp_idx SHALL be held stable until rsp_valid & rsp_ready, then the FSM goes to IDLE.
REQ-012 Timing: handshake in cycle N gives the CSR strobe in N+1, the read response in N+2, and the next req_ready no earlier than N+2 (write) or one cycle after the response handshake (read).
REQ-013 While the FSM is outside IDLE, all req_ready bits SHALL be 0; rsp_ready held low SHALL stall indefinitely without losing data.
REQ-014 Address and data outputs SHALL be 0 whenever their strobe is 0.

Reset
REQ-015 reset low SHALL force, asynchronously: FSM = IDLE, pointer = 0, all outputs = 0, any in-flight request discarded.
REQ-016 After reset deasserts, the first grant SHALL go to the lowest-index valid requester.

Configuration
REQ-017 With LSU_CSR_PERF_EN defined, the block SHALL add outputs perf_reads, perf_writes and perf_stalls (each 32 bits, wrapping, reset 0).
- perf_reads / perf_writes increment on each read / write strobe.
- perf_stalls increments for each cycle with any req_valid high and no handshake.
REQ-018 Without LSU_CSR_PERF_EN, these ports and counters SHALL NOT exist, and the remaining behaviour SHALL be identical.

Structure
REQ-019 The FSM state enum SHALL live in VX_gpu_pkg.
REQ-020 Arbitration SHALL be a sub-module VX_rr_arbiter (NUM_REQS parameter; inputs requests and advance; outputs one-hot grant and index).

Verification
REQ-021 Bench SHALL cover:
- Single write: req0 write to addr 0x7C0, data 0xA5 per lane -> csr_write_enable=1 for one cycle in N+1 with addr 0x7C0; rsp_valid stays 0.
- Single read: req1 read of 0x7C1 while csr_read_data=0x1234 -> rsp_valid in N+2 with rsp_idx=1 and rsp_data=0x1234.
- Contention: both requesters valid continuously -> grants alternate 0,1,0,1.
- Backpressure: rsp_ready low for 5 cycles -> rsp_data stable and req_ready all 0 until release.
- Reset mid-operation: reset asserted during ISSUE -> strobes drop immediately; after release, requester 0 is granted first.
- Perf counters (LSU_CSR_PERF_EN): 3 reads and 2 writes -> perf_reads=3, perf_writes=2.
